// File: rtl/dac_spi_pkg.sv
// Shared constants, command codes, FSM encoding and frame layout for the DAC SPI responder.
package dac_spi_pkg;

    localparam int unsigned FRAME_BITS_DEF = 24;
    localparam int unsigned NUM_CH         = 8;
    localparam int unsigned CH_W           = 3;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned SHIFT_W        = 24;
    localparam int unsigned BITCNT_W       = 6;

    typedef enum logic [3:0] {
        CMD_NOP     = 4'h0,
        CMD_WR_IN   = 4'h1,
        CMD_UPD_DAC = 4'h2,
        CMD_WR_UPD  = 4'h3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    typedef struct packed {
        cmd_e              cmd;
        logic [3:0]        addr;
        logic [DATA_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin plus one extra stage for edge detection.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_,
    input  logic din,
    output logic dout,
    output logic rise_c,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize the pin, then keep one delayed copy to compare against.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign dout   = sync_q;
    assign rise_c = sync_q & ~prev_q;
    assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/dac_spi_responder.sv
// Octal 16-bit DAC input-stage model: oversampled SPI slave, frame decode, input/DAC registers.
// Optional build macro DAC_RSP_SDO_EN enables daisy-chain readback on sdo; otherwise sdo is tied 0.
module dac_spi_responder
    import dac_spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              sclk,
    input  logic              sdin,
    input  logic              sync_,
    input  logic              ldac_,
    output logic              sdo,
    output logic [DATA_W-1:0] dac1,
    output logic [DATA_W-1:0] dac2,
    output logic [DATA_W-1:0] dac3,
    output logic [DATA_W-1:0] dac4,
    output logic [DATA_W-1:0] dac5,
    output logic [DATA_W-1:0] dac6,
    output logic [DATA_W-1:0] dac7,
    output logic [DATA_W-1:0] dac8,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              cmd_err,
    output logic [7:0]        last_cmd,
    output logic [CNT_W-1:0]  frame_cnt
);

    state_e                state_q;
    state_e                state_d;
    logic [SHIFT_W-1:0]    shreg_q;
    logic [BITCNT_W-1:0]   bit_cnt_q;
    logic [DATA_W-1:0]     in_reg_q  [NUM_CH];
    logic [DATA_W-1:0]     dac_reg_q [NUM_CH];

    logic                  sclk_s;
    logic                  sclk_rise_c;
    logic                  sclk_fall_c;
    logic                  sync_s;
    logic                  sync_rise_c;
    logic                  sync_fall_c;
    logic [1:0]            sdin_ff;
    logic [1:0]            ldac_ff;
    logic                  sdin_s;
    logic                  ldac_s;

    frame_t                frm_c;
    logic [CH_W-1:0]       ch_c;
    logic                  len_ok_c;
    logic                  cmd_ok_c;
    logic                  decode_ok_c;
    logic                  wr_in_c;
    logic                  wr_dac_c;
    logic                  upd_dac_c;
    logic                  unused_sig;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .reset_ (reset_),
        .din    (sclk),
        .dout   (sclk_s),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    // sync_ idles high, so its synchronizer resets high to avoid a phantom frame after reset.
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sync (
        .clk    (clk),
        .reset_ (reset_),
        .din    (sync_),
        .dout   (sync_s),
        .rise_c (sync_rise_c),
        .fall_c (sync_fall_c)
    );

    // Level-only synchronizers for data and load pins.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sdin_ff <= 2'b00;
            ldac_ff <= 2'b11;
        end else begin
            sdin_ff <= {sdin_ff[0], sdin};
            ldac_ff <= {ldac_ff[0], ldac_};
        end
    end

    assign sdin_s = sdin_ff[1];
    assign ldac_s = ldac_ff[1];

    // FSM state register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: open on sync_ low, close on sync_ rising, decode for one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!sync_s)     state_d = ST_SHIFT;
            ST_SHIFT:  if (sync_rise_c) state_d = ST_DECODE;
            ST_DECODE:                  state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Shift MSB-first on sclk falling; a fall coinciding with sync_ rising is not taken.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            bit_cnt_q <= '0;
        end else if (state_q == ST_SHIFT && sclk_fall_c && !sync_rise_c) begin
            shreg_q <= {shreg_q[SHIFT_W-2:0], sdin_s};
            if (bit_cnt_q != '1) begin
                bit_cnt_q <= bit_cnt_q + BITCNT_W'(1);
            end
        end
    end

    assign frm_c       = frame_t'(shreg_q);
    assign ch_c        = frm_c.addr[CH_W-1:0];
    assign len_ok_c    = (bit_cnt_q >= BITCNT_W'(FRAME_BITS));
    assign cmd_ok_c    = (frm_c.addr < 4'(NUM_CH)) &&
                         (frm_c.cmd inside {CMD_NOP, CMD_WR_IN, CMD_UPD_DAC, CMD_WR_UPD});
    assign decode_ok_c = (state_q == ST_DECODE) && len_ok_c && cmd_ok_c;

    // Register-file write enables for an accepted frame.
    always_comb begin
        wr_in_c   = 1'b0;
        wr_dac_c  = 1'b0;
        upd_dac_c = 1'b0;
        if (decode_ok_c) begin
            unique case (frm_c.cmd)
                CMD_WR_IN: begin
                    wr_in_c  = 1'b1;
                    wr_dac_c = !ldac_s;
                end
                CMD_UPD_DAC: upd_dac_c = 1'b1;
                CMD_WR_UPD: begin
                    wr_in_c  = 1'b1;
                    wr_dac_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Input and DAC register banks.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            in_reg_q  <= '{default: '0};
            dac_reg_q <= '{default: '0};
        end else begin
            if (wr_in_c) begin
                in_reg_q[ch_c] <= frm_c.data;
            end
            if (wr_dac_c) begin
                dac_reg_q[ch_c] <= frm_c.data;
            end else if (upd_dac_c) begin
                dac_reg_q[ch_c] <= in_reg_q[ch_c];
            end
        end
    end

    // Status pulses, last command byte and valid-frame counter.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            cmd_err     <= 1'b0;
            last_cmd    <= '0;
            frame_cnt   <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            cmd_err     <= 1'b0;
            if (state_q == ST_DECODE) begin
                if (!len_ok_c) begin
                    frame_err <= 1'b1;
                end else begin
                    frame_valid <= 1'b1;
                    last_cmd    <= shreg_q[SHIFT_W-1 -: 8];
                    frame_cnt   <= frame_cnt + CNT_W'(1);
                    cmd_err     <= !cmd_ok_c;
                end
            end
        end
    end

    assign dac1 = dac_reg_q[0];
    assign dac2 = dac_reg_q[1];
    assign dac3 = dac_reg_q[2];
    assign dac4 = dac_reg_q[3];
    assign dac5 = dac_reg_q[4];
    assign dac6 = dac_reg_q[5];
    assign dac7 = dac_reg_q[6];
    assign dac8 = dac_reg_q[7];

`ifdef DAC_RSP_SDO_EN
    logic sdo_q;

    // Daisy-chain echo: present the oldest shifted bit on each sclk rising, zero outside a frame.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sdo_q <= 1'b0;
        end else if (state_q != ST_SHIFT) begin
            sdo_q <= 1'b0;
        end else if (sclk_rise_c) begin
            sdo_q <= shreg_q[SHIFT_W-1];
        end
    end

    assign sdo        = sdo_q;
    assign unused_sig = ^{sclk_s, sync_fall_c};
`else
    assign sdo        = 1'b0;
    assign unused_sig = ^{sclk_s, sync_fall_c, sclk_rise_c};
`endif

endmodule

// File: tb/tb_dac_spi_responder.sv
// Self-checking bench for dac_spi_responder: vector table, latency/reset/sdo sequences, random frames.
module tb_dac_spi_responder;

    logic        clk = 1'b0;
    logic        reset_;
    logic        sclk;
    logic        sdin;
    logic        sync_;
    logic        ldac_;
    logic        sdo;
    logic [15:0] dac1, dac2, dac3, dac4, dac5, dac6, dac7, dac8;
    logic        frame_valid;
    logic        frame_err;
    logic        cmd_err;
    logic [7:0]  last_cmd;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    dac_spi_responder dut (
        .clk         (clk),
        .reset_      (reset_),
        .sclk        (sclk),
        .sdin        (sdin),
        .sync_       (sync_),
        .ldac_       (ldac_),
        .sdo         (sdo),
        .dac1        (dac1),
        .dac2        (dac2),
        .dac3        (dac3),
        .dac4        (dac4),
        .dac5        (dac5),
        .dac6        (dac6),
        .dac7        (dac7),
        .dac8        (dac8),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .cmd_err     (cmd_err),
        .last_cmd    (last_cmd),
        .frame_cnt   (frame_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Running pulse totals, sampled away from the active edge.
    int fv_total = 0;
    int fe_total = 0;
    int ce_total = 0;
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_total++;
        if (frame_err   === 1'b1) fe_total++;
        if (cmd_err     === 1'b1) ce_total++;
    end

    // Reference model state.
    logic [15:0] m_in  [8];
    logic [15:0] m_dac [8];
    logic [7:0]  m_last;
    logic [15:0] m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_in[i]  = 16'h0;
            m_dac[i] = 16'h0;
        end
        m_last = 8'h0;
        m_cnt  = 16'h0;
    endfunction

    // Expected {frame_valid, frame_err, cmd_err} for a frame of n counted bits ending in w.
    function automatic logic [2:0] predict(input logic [23:0] w, input int n);
        int cmd  = int'(w[23:20]);
        int addr = int'(w[19:16]);
        if (n < 24) return 3'b010;
        if (cmd > 3 || addr > 7) return 3'b101;
        return 3'b100;
    endfunction

    function automatic void model_frame(input logic [23:0] w, input int n, input logic ld);
        int cmd  = int'(w[23:20]);
        int addr = int'(w[19:16]);
        if (n < 24) return;
        m_cnt  = m_cnt + 16'd1;
        m_last = w[23:16];
        if (cmd > 3 || addr > 7) return;
        case (cmd)
            1: begin
                m_in[addr] = w[15:0];
                if (!ld) m_dac[addr] = w[15:0];
            end
            2: m_dac[addr] = m_in[addr];
            3: begin
                m_in[addr]  = w[15:0];
                m_dac[addr] = w[15:0];
            end
            default: ;
        endcase
    endfunction

    function automatic logic [127:0] model_dacs();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = m_dac[i];
        return v;
    endfunction

    function automatic logic [127:0] dut_dacs();
        return {dac8, dac7, dac6, dac5, dac4, dac3, dac2, dac1};
    endfunction

    function automatic logic [15:0] dut_dac(input int ch);
        case (ch)
            0: return dac1;
            1: return dac2;
            2: return dac3;
            3: return dac4;
            4: return dac5;
            5: return dac6;
            6: return dac7;
            default: return dac8;
        endcase
    endfunction

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI bit: data changes with sclk rising, responder samples on falling; sdo read before falling.
    task automatic shift_bit(input logic b, output logic so);
        sclk = 1'b1;
        sdin = b;
        clk_n(4);
        so   = sdo;
        sclk = 1'b0;
        clk_n(4);
    endtask

    // Frame of n bits (bits[n-1] first); optionally one extra sclk whose fall coincides with sync_ rising.
    task automatic send_frame(input logic [63:0] bits, input int n, input logic co);
        logic so;
        sync_ = 1'b0;
        clk_n(4);
        for (int i = n - 1; i >= 0; i--) shift_bit(bits[i], so);
        if (co) begin
            sclk = 1'b1;
            sdin = 1'b1;
            clk_n(4);
            sclk  = 1'b0;
            sync_ = 1'b1;
        end else begin
            sync_ = 1'b1;
        end
        clk_n(8);
    endtask

    task automatic run_frame(input string name, input logic [23:0] w, input int n, input logic ld,
                             input logic co, input logic [2:0] exp_pulses);
        int fv0 = fv_total;
        int fe0 = fe_total;
        int ce0 = ce_total;
        logic [63:0] bits;
        ldac_ = ld;
        clk_n(3);
        bits = {32'($urandom()), 8'($urandom()), w};
        send_frame(bits, n, co);
        model_frame(w, n, ld);
        check({name, " frame_valid"}, 128'(fv_total - fv0), 128'(exp_pulses[2]));
        check({name, " frame_err"},   128'(fe_total - fe0), 128'(exp_pulses[1]));
        check({name, " cmd_err"},     128'(ce_total - ce0), 128'(exp_pulses[0]));
        check({name, " frame_cnt"},   128'(frame_cnt), 128'(m_cnt));
        check({name, " last_cmd"},    128'(last_cmd), 128'(m_last));
        check({name, " dacs"},        dut_dacs(), model_dacs());
    endtask

    typedef struct {
        logic [23:0] word;
        int          nbits;
        logic        ld;
        logic        co;
        logic [2:0]  pulses;
        int          ch;
        logic [15:0] val;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [63:0] cap;
        logic        so;
        int          fv0;
        logic [127:0] exp_sdo;

        tbl[0]  = '{24'h30ABCD, 24, 1'b1, 1'b0, 3'b100, 0, 16'hABCD};
        tbl[1]  = '{24'h1512F0, 24, 1'b1, 1'b0, 3'b100, 5, 16'h0000};
        tbl[2]  = '{24'h250000, 24, 1'b1, 1'b0, 3'b100, 5, 16'h12F0};
        tbl[3]  = '{24'h3277AA, 23, 1'b1, 1'b0, 3'b010, 2, 16'h0000};
        tbl[4]  = '{24'h37FFFF, 26, 1'b1, 1'b0, 3'b100, 7, 16'hFFFF};
        tbl[5]  = '{24'h391234, 24, 1'b1, 1'b0, 3'b101, 1, 16'h0000};
        tbl[6]  = '{24'h701234, 24, 1'b1, 1'b0, 3'b101, 0, 16'hABCD};
        tbl[7]  = '{24'h1300C3, 24, 1'b0, 1'b0, 3'b100, 3, 16'h00C3};
        tbl[8]  = '{24'h00FFFF, 24, 1'b1, 1'b0, 3'b100, 7, 16'hFFFF};
        tbl[9]  = '{24'h3155AA, 24, 1'b1, 1'b1, 3'b100, 1, 16'h55AA};
        tbl[10] = '{24'h3366AA, 23, 1'b1, 1'b1, 3'b010, 2, 16'h0000};

        reset_ = 1'b0;
        sclk   = 1'b0;
        sdin   = 1'b0;
        sync_  = 1'b1;
        ldac_  = 1'b1;
        model_reset();
        clk_n(3);
        check("reset dacs",      dut_dacs(), 128'h0);
        check("reset pulses",    128'({frame_valid, frame_err, cmd_err}), 128'h0);
        check("reset last_cmd",  128'(last_cmd), 128'h0);
        check("reset frame_cnt", 128'(frame_cnt), 128'h0);
        check("reset sdo",       128'(sdo), 128'h0);
        reset_ = 1'b1;
        clk_n(5);

        for (int i = 0; i < 11; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].word, tbl[i].nbits, tbl[i].ld, tbl[i].co,
                      tbl[i].pulses);
            check($sformatf("vec%0d dac%0d", i, tbl[i].ch + 1), 128'(dut_dac(tbl[i].ch)),
                  128'(tbl[i].val));
        end

        // Latency from sync_ rising to visible update, and single-cycle pulse width.
        ldac_ = 1'b1;
        clk_n(3);
        sync_ = 1'b0;
        clk_n(4);
        for (int i = 23; i >= 0; i--) begin
            logic [23:0] w = 24'h341234;
            shift_bit(w[i], so);
        end
        sync_ = 1'b1;
        clk_n(3);
        check("lat early frame_valid", 128'(frame_valid), 128'h0);
        check("lat early dac5",        128'(dac5), 128'h0);
        clk_n(1);
        check("lat frame_valid",       128'(frame_valid), 128'h1);
        check("lat dac5",              128'(dac5), 128'h1234);
        clk_n(1);
        check("lat pulse width",       128'(frame_valid), 128'h0);
        model_frame(24'h341234, 24, 1'b1);
        clk_n(4);

        // Randomized frames against the model.
        for (int i = 0; i < 40; i++) begin
            logic [23:0] w;
            int          n;
            w[23:20] = 4'($urandom_range(0, 5));
            w[19:16] = 4'($urandom_range(0, 9));
            w[15:0]  = 16'($urandom());
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 23)) : int'($urandom_range(24, 28));
            run_frame($sformatf("rnd%0d", i), w, n, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0), predict(w, n));
        end

        // Reset in the middle of a frame.
        ldac_ = 1'b1;
        clk_n(3);
        sync_ = 1'b0;
        clk_n(4);
        for (int i = 23; i >= 12; i--) begin
            logic [23:0] w = 24'h330001;
            shift_bit(w[i], so);
        end
        reset_ = 1'b0;
        clk_n(1);
        check("midreset dacs",      dut_dacs(), 128'h0);
        check("midreset frame_cnt", 128'(frame_cnt), 128'h0);
        check("midreset last_cmd",  128'(last_cmd), 128'h0);
        sync_ = 1'b1;
        sclk  = 1'b0;
        clk_n(3);
        fv0 = fv_total + fe_total + ce_total;
        reset_ = 1'b1;
        model_reset();
        clk_n(10);
        check("midreset no pulse", 128'(fv_total + fe_total + ce_total - fv0), 128'h0);
        run_frame("after reset", 24'h32BEEF, 24, 1'b1, 1'b0, 3'b100);
        check("after reset dac3", 128'(dac3), 128'hBEEF);
        check("after reset dac4", 128'(dac4), 128'h0);

        // Two 24-bit bursts under one sync_ low; second burst reads the first back on sdo.
        ldac_ = 1'b1;
        clk_n(3);
        fv0 = fv_total;
        cap = '0;
        sync_ = 1'b0;
        clk_n(4);
        for (int i = 23; i >= 0; i--) begin
            logic [23:0] w = 24'h34AAAA;
            shift_bit(w[i], so);
        end
        for (int i = 0; i < 24; i++) begin
            shift_bit(1'b0, so);
            cap = {cap[62:0], so};
        end
        sync_ = 1'b1;
        clk_n(8);
        model_frame(24'h000000, 48, 1'b1);
`ifdef DAC_RSP_SDO_EN
        exp_sdo = 128'h34AAAA;
`else
        exp_sdo = 128'h0;
`endif
        check("sdo echo",         128'(cap[23:0]), exp_sdo);
        check("sdo idle",         128'(sdo), 128'h0);
        check("long frame valid", 128'(fv_total - fv0), 128'h1);
        check("long frame dacs",  dut_dacs(), model_dacs());
        check("long frame cnt",   128'(frame_cnt), 128'(m_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
